// File: rtl/alu_result_stage.sv
// Two-entry result buffer between the adder and writeback. It also holds the
// architectural Z/N/V/C flags, which retiring entries update, and evaluates condition codes.
module alu_result_stage #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_sum,
  input  logic        in_v,
  input  logic        in_c,
  input  logic        in_set_flags,
  input  logic [2:0]  in_dest,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_result,
  output logic [2:0]  out_dest,
  input  logic        flush,
  input  logic [2:0]  cond,
  output logic        cond_true,
  output logic        flag_z,
  output logic        flag_n,
  output logic        flag_v,
  output logic        flag_c
);

  if (DEPTH != 2) begin : g_bad_depth
    $error("alu_result_stage: DEPTH must be 2");
  end

  typedef struct packed {
    logic [15:0] sum;
    logic        v;
    logic        c;
    logic        set_flags;
    logic [2:0]  dest;
  } entry_t;

  typedef struct packed {
    logic z;
    logic n;
    logic v;
    logic c;
  } flags_t;

  entry_t     entries_q [DEPTH];
  logic [1:0] count_q, count_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic       wr_ptr_q, wr_ptr_d;
  flags_t     flags_q, flags_d;

  entry_t head;
  logic   push, pop;

  assign head      = entries_q[rd_ptr_q];
  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  // A flush drops a same-cycle push; the pop is cancelled in the next-state logic.
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready;

  assign out_result = out_valid ? head.sum  : 16'd0;
  assign out_dest   = out_valid ? head.dest : 3'd0;

  always_comb begin
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    flags_d  = flags_q;
    if (flush) begin
      count_d  = 2'd0;
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
    end else begin
      if (push) wr_ptr_d = ~wr_ptr_q;
      if (pop) begin
        rd_ptr_d = ~rd_ptr_q;
        if (head.set_flags) begin
          flags_d = '{z: (head.sum == 16'd0), n: head.sum[15], v: head.v, c: head.c};
        end
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q  <= 2'd0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      flags_q  <= '0;
    end else begin
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      flags_q  <= flags_d;
    end
  end

  // NOTE: payload storage is deliberately not reset; count gates its visibility.
  always_ff @(posedge clk) begin
    if (push) begin
      entries_q[wr_ptr_q] <= '{sum: in_sum, v: in_v, c: in_c,
                               set_flags: in_set_flags, dest: in_dest};
    end
  end

  assign flag_z = flags_q.z;
  assign flag_n = flags_q.n;
  assign flag_v = flags_q.v;
  assign flag_c = flags_q.c;

  always_comb begin
    cond_true = 1'b0;
    case (cond)
      3'd0: cond_true = 1'b1;
      3'd1: cond_true = flags_q.z;
      3'd2: cond_true = ~flags_q.z;
      3'd3: cond_true = flags_q.n ^ flags_q.v;
      3'd4: cond_true = ~(flags_q.n ^ flags_q.v);
      3'd5: cond_true = flags_q.c;
      3'd6: cond_true = ~flags_q.c;
      default: cond_true = 1'b0;
    endcase
  end

endmodule
